// File: rtl/ipml_hsst_lane_rst_seq_v1_0_if.sv
// Lane reset sequencer control/status bundle: lane-manager side drives the level/lock inputs.
// Latency: pure wiring, no storage.
// Backpressure: none; every signal is a level or a single-cycle pulse sampled each cycle.
interface ipml_hsst_lane_rst_seq_v1_0_if;
    logic       start;
    logic       restart;
    logic       pll_lock;
    logic       cdr_lock;
    logic       align_ok;
    logic       lane_pd;
    logic       pma_rst;
    logic       pcs_rst;
    logic       rx_ready;
    logic       fault;
    logic [2:0] fsm_st;
    logic [3:0] retry_cnt;

    modport master (
        output start, restart, pll_lock, cdr_lock, align_ok,
        input  lane_pd, pma_rst, pcs_rst, rx_ready, fault, fsm_st, retry_cnt
    );

    modport slave (
        input  start, restart, pll_lock, cdr_lock, align_ok,
        output lane_pd, pma_rst, pcs_rst, rx_ready, fault, fsm_st, retry_cnt
    );
endinterface

// File: rtl/ipml_hsst_lane_rst_seq_v1_0.sv
// HSST receive-lane reset sequencer: PLL wait, PMA reset, CDR wait, PCS reset, align wait, with timeout retries.
// Latency: inputs sampled at edge N show in fsm_st and all outputs right after edge N (outputs decoded from next state).
// Backpressure: none; lock inputs are levels, restart is a one-cycle pulse that only matters in FAULT.
module ipml_hsst_lane_rst_seq_v1_0 #(
    parameter int TO_CNTR_WIDTH   = 18,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int MAX_RETRY       = 3
) (
    input  logic clk,
    input  logic rst_n,
    ipml_hsst_lane_rst_seq_v1_0_if.slave lane
);
    localparam int MSB = TO_CNTR_WIDTH - 1;
    localparam logic [TO_CNTR_WIDTH-1:0] HOLD_LAST  = TO_CNTR_WIDTH'(RST_HOLD_CYCLES - 1);
    localparam logic [3:0]               RETRY_LAST = 4'(MAX_RETRY - 1);
    localparam logic [3:0]               RETRY_MAX  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PLL_WAIT   = 3'd1,
        ST_PMA_RST    = 3'd2,
        ST_CDR_WAIT   = 3'd3,
        ST_PCS_RST    = 3'd4,
        ST_ALIGN_WAIT = 3'd5,
        ST_READY      = 3'd6,
        ST_FAULT      = 3'd7
    } state_t;

    state_t                   st_q, st_d;
    logic [TO_CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]               retry_q, retry_d;
    logic [4:0]               out_q, out_d;   // {lane_pd, pma_rst, pcs_rst, rx_ready, fault}
    logic                     timeout;
    logic                     hold_done;
    logic                     exhausted;

    // Counter saturates once the MSB is set, so the MSB alone marks an expired wait.
    assign timeout   = cnt_q[MSB];
    assign hold_done = (cnt_q == HOLD_LAST);
    // Greater-or-equal keeps retry_cnt pinned at MAX_RETRY even from an unexpected value.
    assign exhausted = (retry_q >= RETRY_LAST);

    // Next-state and retry bookkeeping; lock inputs are checked before timeouts so a late lock still wins.
    always_comb begin
        st_d    = st_q;
        retry_d = retry_q;
        if (st_q != ST_IDLE && !lane.start) begin
            st_d    = ST_IDLE;
            retry_d = '0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (lane.start) st_d = ST_PLL_WAIT;
                end
                ST_PLL_WAIT: begin
                    if (lane.pll_lock) begin
                        st_d = ST_PMA_RST;
                    end else if (timeout) begin
                        st_d    = exhausted ? ST_FAULT : ST_PLL_WAIT;
                        retry_d = exhausted ? RETRY_MAX : retry_q + 4'd1;
                    end
                end
                ST_PMA_RST: begin
                    if (!lane.pll_lock)  st_d = ST_PLL_WAIT;
                    else if (hold_done)  st_d = ST_CDR_WAIT;
                end
                ST_CDR_WAIT: begin
                    if (!lane.pll_lock) begin
                        st_d = ST_PLL_WAIT;
                    end else if (lane.cdr_lock) begin
                        st_d = ST_PCS_RST;
                    end else if (timeout) begin
                        st_d    = exhausted ? ST_FAULT : ST_PMA_RST;
                        retry_d = exhausted ? RETRY_MAX : retry_q + 4'd1;
                    end
                end
                ST_PCS_RST: begin
                    if (!lane.pll_lock)      st_d = ST_PLL_WAIT;
                    else if (!lane.cdr_lock) st_d = ST_PMA_RST;
                    else if (hold_done)      st_d = ST_ALIGN_WAIT;
                end
                ST_ALIGN_WAIT: begin
                    if (!lane.pll_lock) begin
                        st_d = ST_PLL_WAIT;
                    end else if (!lane.cdr_lock) begin
                        st_d = ST_PMA_RST;
                    end else if (lane.align_ok) begin
                        st_d = ST_READY;
                    end else if (timeout) begin
                        st_d    = exhausted ? ST_FAULT : ST_PMA_RST;
                        retry_d = exhausted ? RETRY_MAX : retry_q + 4'd1;
                    end
                end
                ST_READY: begin
                    // Losing alignment alone is left to the link layer; only lock losses re-sequence.
                    if (!lane.pll_lock)      st_d = ST_PLL_WAIT;
                    else if (!lane.cdr_lock) st_d = ST_PMA_RST;
                end
                ST_FAULT: begin
                    if (lane.restart) begin
                        st_d    = ST_IDLE;
                        retry_d = '0;
                    end
                end
                default: begin
                    st_d = ST_IDLE;
                end
            endcase
        end
    end

    // Shared dwell counter: restarts on every state change, otherwise counts up to the timeout bit.
    always_comb begin
        cnt_d = cnt_q;
        if (st_d != st_q)  cnt_d = '0;
        else if (!cnt_q[MSB]) cnt_d = cnt_q + TO_CNTR_WIDTH'(1);
    end

    // Output decode from the next state so outputs and fsm_st move on the same edge.
    always_comb begin
        out_d = 5'b11100;
        case (st_d)
            ST_IDLE:       out_d = 5'b11100;
            ST_PLL_WAIT:   out_d = 5'b01100;
            ST_PMA_RST:    out_d = 5'b01100;
            ST_CDR_WAIT:   out_d = 5'b00100;
            ST_PCS_RST:    out_d = 5'b00100;
            ST_ALIGN_WAIT: out_d = 5'b00000;
            ST_READY:      out_d = 5'b00010;
            ST_FAULT:      out_d = 5'b01101;
            default:       out_d = 5'b11100;
        endcase
    end

    // State, counter, retry and output registers with asynchronous reset to the powered-down IDLE values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            out_q   <= 5'b11100;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            out_q   <= out_d;
        end
    end

    assign lane.lane_pd   = out_q[4];
    assign lane.pma_rst   = out_q[3];
    assign lane.pcs_rst   = out_q[2];
    assign lane.rx_ready  = out_q[1];
    assign lane.fault     = out_q[0];
    assign lane.fsm_st    = st_q;
    assign lane.retry_cnt = retry_q;
endmodule

// File: doc/ipml_hsst_lane_rst_seq_v1_0.md
# ipml_hsst_lane_rst_seq_v1_0

Per-lane HSST reset sequencer that brings a receive lane from power-up to ready by stepping through PLL-lock wait, PMA reset, CDR-lock wait, PCS reset and word-alignment wait. Each wait state is guarded by an integrated timeout watchdog; a timeout triggers a bounded number of PMA-level retries before the lane is declared faulted. It sits between the HSST hard macro's reset and status pins and the PCIe/link layer, which consumes `rx_ready`.

## Interface
- `TO_CNTR_WIDTH`, default 18: timeout in any wait state = 2**(TO_CNTR_WIDTH-1) cycles (131072 by default).
- `RST_HOLD_CYCLES`, default 16: assertion length of the PMA and PCS resets in cycles; legal range 1 to 255.
- `MAX_RETRY`, default 3: number of timeout retries before FAULT; legal range 1 to 15.

Ports:
- `clk`  in  1  sequencer clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  level; 1 = bring the lane up, 0 = hold it down.
- `restart`  in  1  single-cycle pulse; exits FAULT.
- `pll_lock`  in  1  PLL lock; already synchronous to `clk`.
- `cdr_lock`  in  1  CDR lock; synchronous.
- `align_ok`  in  1  word-alignment done; synchronous.
- `lane_pd`  out  1  lane power-down; 1 = powered down.
- `pma_rst`  out  1  PMA reset, active-high.
- `pcs_rst`  out  1  PCS reset, active-high.
- `rx_ready`  out  1  lane usable.
- `fault`  out  1  retries exhausted.
- `fsm_st`  out  3  current state encoding.
- `retry_cnt`  out  4  timeouts taken since the last IDLE.

## Operation
State encodings and outputs (`lane_pd` / `pma_rst` / `pcs_rst` / `rx_ready` / `fault`):
- IDLE = 0: 1/1/1/0/0.
- PLL_WAIT = 1: 0/1/1/0/0.
- PMA_RST = 2: 0/1/1/0/0.
- CDR_WAIT = 3: 0/0/1/0/0.
- PCS_RST = 4: 0/0/1/0/0.
- ALIGN_WAIT = 5: 0/0/0/0/0.
- READY = 6: 0/0/0/1/0.
- FAULT = 7: 0/1/1/0/1.

Counters:
- A single shared counter `cnt` of TO_CNTR_WIDTH bits clears on every state change.
- While the state is unchanged, `cnt` increments by 1 each cycle and saturates once bit TO_CNTR_WIDTH-1 is set.
- Timeout means `cnt[TO_CNTR_WIDTH-1]` = 1 in PLL_WAIT, CDR_WAIT or ALIGN_WAIT.

Transitions (the first matching rule wins):
- Any state except IDLE, when `start` = 0: go to IDLE and clear `retry_cnt`.
- IDLE, when `start` = 1: go to PLL_WAIT.
- PLL_WAIT:
  - `pll_lock` = 1: go to PMA_RST.
  - Timeout: take the retry rule, with PLL_WAIT as the retry target.
- PMA_RST:
  - `pll_lock` = 0: go to PLL_WAIT.
  - `cnt` = RST_HOLD_CYCLES-1: go to CDR_WAIT.
- CDR_WAIT:
  - `pll_lock` = 0: go to PLL_WAIT.
  - `cdr_lock` = 1: go to PCS_RST.
  - Timeout: take the retry rule.
- PCS_RST:
  - `pll_lock` = 0: go to PLL_WAIT.
  - `cdr_lock` = 0: go to PMA_RST.
  - `cnt` = RST_HOLD_CYCLES-1: go to ALIGN_WAIT.
- ALIGN_WAIT:
  - Same lock-loss rules as PCS_RST.
  - `align_ok` = 1: go to READY.
  - Timeout: take the retry rule.
- READY:
  - `pll_lock` = 0: go to PLL_WAIT.
  - `cdr_lock` = 0: go to PMA_RST.
  - Loss of `align_ok`: ignored.
  - Lock losses do not increment `retry_cnt`.
- Retry rule:
  - If `retry_cnt` = MAX_RETRY-1: go to FAULT with `retry_cnt` = MAX_RETRY.
  - Otherwise: increment `retry_cnt` and go to PMA_RST (PLL_WAIT for a PLL timeout).
- FAULT:
  - `restart` = 1: go to IDLE and clear `retry_cnt`.
  - Otherwise: stay; inputs are ignored.

Other rules:
- `retry_cnt` saturates at MAX_RETRY.
- If `restart` and `start` = 0 occur together, the result is IDLE either way.

## Timing
- All outputs are registered and decoded from the next state, so they change on the same edge as `fsm_st`. There is no combinational path from inputs to outputs.
- Reset values: `fsm_st` = 0, `lane_pd` = 1, `pma_rst` = 1, `pcs_rst` = 1, `rx_ready` = 0, `fault` = 0, `retry_cnt` = 0, `cnt` = 0.
- Latency:
  - An input condition sampled at edge N is reflected in the state and outputs after edge N.
  - `pma_rst` and `pcs_rst` each stay high for exactly RST_HOLD_CYCLES cycles inside their reset state.
- Timeout fires on the cycle where `cnt` reaches 2**(TO_CNTR_WIDTH-1), measured from state entry.
- Assertion of `rst_n` mid-sequence forces reset values asynchronously. After deassertion the sequence restarts from IDLE.
- If a lock input and a timeout arrive in the same cycle, the lock input wins.

## Test plan
- Nominal bring-up:
  - Stimulus: `start` = 1; `pll_lock` at +10 cycles; `cdr_lock` at +40; `align_ok` at +80.
  - Required response: `fsm_st` sequence 0, 1, 2, 3, 4, 5, 6. `pma_rst` high for 16 cycles after PLL lock; `rx_ready` = 1 and `retry_cnt` = 0.
- CDR timeout and retries (TO_CNTR_WIDTH = 6):
  - Stimulus: `cdr_lock` held at 0.
  - Required response: three 32-cycle timeouts; `retry_cnt` goes 1, 2, then FAULT with `fault` = 1 and `retry_cnt` = 3.
  - Follow-up: `restart` pulse gives IDLE, then re-entry into PLL_WAIT.
- Lock loss in READY:
  - Drop `cdr_lock` gives PMA_RST with `rx_ready` low on the next edge and `retry_cnt` unchanged.
  - Drop `pll_lock` gives PLL_WAIT.
- Simultaneous events:
  - `cdr_lock` rising in the same cycle as a CDR_WAIT timeout gives PCS_RST, not a retry.
  - `start` = 0 together with a timeout gives IDLE.
- Asynchronous reset:
  - Stimulus: assert `rst_n` mid-PCS_RST.
  - Required response: all outputs at reset values within the same cycle; recovery from IDLE after deassertion.
